instruction_decode: RTL and testbench
=====================================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, width of the program-counter path.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port i_instruction, input, 32, instruction word from fetch.
REQ-005 SHALL have port i_process_counter, input, PC_WIDTH, PC of i_instruction.
REQ-006 SHALL have port i_valid, input, 1, fetch output valid.
REQ-007 SHALL have port i_stall, input, 1, downstream hold request.
REQ-008 SHALL have port i_flush, input, 1, squash request (taken jump/branch).
REQ-009 SHALL have ports i_wb_en (1), i_wb_addr (5) and i_wb_data (32), all inputs, forming the register-file write-back port.
REQ-010 SHALL have port o_valid, output, 1, decoded bundle valid.
REQ-011 SHALL have port o_process_counter, output, PC_WIDTH, PC of the decoded instruction.
REQ-012 SHALL have ports o_rs1_data and o_rs2_data, outputs, 32 each, source operands.
REQ-013 SHALL have ports o_imm (32), o_rd (5), o_funct3 (3) and o_alu_op (4), all outputs.
REQ-014 SHALL have control outputs o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_use_imm and o_illegal, each 1 bit.

Function
REQ-015 SHALL contain a 32x32 register file; x0 SHALL read 0 and ignore writes.
REQ-016 Write-back SHALL occur on a clk edge when i_wb_en=1, i_wb_addr!=0 and rst=0.
REQ-017 Reads SHALL bypass: if i_wb_en=1 and i_wb_addr equals rs1 or rs2 (nonzero) in the capture cycle, i_wb_data SHALL be captured instead of the stored value.
REQ-018 Latency SHALL be one cycle: the bundle for a capture-edge input appears on the outputs immediately after that edge.
REQ-019 Priority per edge SHALL be rst > i_flush > i_stall > capture.
REQ-020 Flush SHALL load a bubble: all outputs 0 (o_valid=0), regardless of i_stall.
REQ-021 Stall SHALL hold every output unchanged; write-back SHALL still occur, so held operand outputs may be stale (this is a hazard-unit concern).
REQ-022 Capture with i_valid=0 SHALL load a bubble.
REQ-023 Immediates SHALL be sign-extended as follows: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}.
REQ-024 Opcode decode SHALL follow this table:
- OP-IMM 0010011: reg_write=1, use_imm=1.
- OP 0110011: reg_write=1, use_imm=0.
- LUI 0110111: reg_write=1, use_imm=1, rs1_data forced to 0.
- AUIPC 0010111: reg_write=1, use_imm=1.
- JAL 1101111: reg_write=1, jump=1.
- JALR 1100111: reg_write=1, jump=1, use_imm=1.
- BRANCH 1100011: branch=1.
- LOAD 0000011: reg_write=1, mem_read=1, use_imm=1.
- STORE 0100011: mem_write=1, use_imm=1.
REQ-025 o_alu_op encoding SHALL be 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- OP: selected by funct3, with funct7[5] selecting SUB/SRA.
- OP-IMM: selected by funct3, with funct7[5] affecting only SRAI.
- BRANCH: SUB.
- All other opcodes: ADD.
REQ-026 An unknown opcode SHALL produce o_valid=1, o_illegal=1, all other control bits 0 and o_rd=0.
REQ-027 o_rd SHALL be 0 whenever o_reg_write=0; o_funct3 SHALL be passed through unchanged.

Reset
REQ-028 While rst=1, every output SHALL be 0 at the following edge and all 32 registers SHALL clear to 0.
REQ-029 Write-back SHALL be ignored during reset; reset mid-stall SHALL discard the held bundle.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Reset 10 cycles -> all outputs 0, o_valid=0.
- i_instruction=0x00E00113 (addi x2,x0,14), pc=0, valid -> next edge: o_imm=14, o_rd=2, o_rs1_data=0, alu_op=0, use_imm=1, reg_write=1, o_process_counter=0.
- Write x5=0xDEADBEEF via write-back while decoding add x6,x5,x5 in the same cycle -> o_rs1_data=o_rs2_data=0xDEADBEEF (bypass).
- Stall asserted 3 cycles with changing input -> outputs hold; simultaneous flush+stall -> o_valid=0.
- beq with imm=-8 (0xFE000CE3) -> o_imm=0xFFFFFFF8, branch=1, alu_op=1, o_rd=0.
- Opcode 1111111 -> o_illegal=1, o_valid=1, all other control bits 0.

Source files
------------

// File: rtl/instruction_decode.sv
// RV32I decode stage: register file with write-back bypass, immediate generation
// and control decode into a single registered output bundle (one-cycle latency).
module instruction_decode #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_instruction,
  input  logic [PC_WIDTH-1:0] i_process_counter,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_wb_en,
  input  logic [4:0]          i_wb_addr,
  input  logic [31:0]         i_wb_data,
  output logic                o_valid,
  output logic [PC_WIDTH-1:0] o_process_counter,
  output logic [31:0]         o_rs1_data,
  output logic [31:0]         o_rs2_data,
  output logic [31:0]         o_imm,
  output logic [4:0]          o_rd,
  output logic [2:0]          o_funct3,
  output logic [3:0]          o_alu_op,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_branch,
  output logic                o_jump,
  output logic                o_use_imm,
  output logic                o_illegal
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  function automatic logic signed [DATA_W-1:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [DATA_W-1:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [DATA_W-1:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [DATA_W-1:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [DATA_W-1:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // alt distinguishes SUB/SRA; for OP-IMM the caller only passes it through for shifts.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_add,
                                         input logic alt_shr);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt_add ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt_shr ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [DATA_W-1:0] regs [32];

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic       f7_alt;

  assign opcode = i_instruction[6:0];
  assign rd     = i_instruction[11:7];
  assign funct3 = i_instruction[14:12];
  assign rs1    = i_instruction[19:15];
  assign rs2    = i_instruction[24:20];
  assign f7_alt = i_instruction[30];

  logic signed [DATA_W-1:0] rs1_val, rs2_val, imm_d;
  logic [3:0] alu_d;
  logic reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, use_imm_d, illegal_d;
  logic force_rs1_zero;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0)
      rs1_val = (i_wb_en && i_wb_addr == rs1) ? i_wb_data : regs[rs1];
    if (rs2 != 5'd0)
      rs2_val = (i_wb_en && i_wb_addr == rs2) ? i_wb_data : regs[rs2];
  end

  always_comb begin
    imm_d          = '0;
    alu_d          = ALU_ADD;
    reg_write_d    = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    branch_d       = 1'b0;
    jump_d         = 1'b0;
    use_imm_d      = 1'b0;
    illegal_d      = 1'b0;
    force_rs1_zero = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        reg_write_d = 1'b1;
        use_imm_d   = 1'b1;
        imm_d       = imm_i(i_instruction);
        alu_d       = alu_sel(funct3, 1'b0, f7_alt);
      end
      OPC_OP: begin
        reg_write_d = 1'b1;
        alu_d       = alu_sel(funct3, f7_alt, f7_alt);
      end
      OPC_LUI: begin
        reg_write_d    = 1'b1;
        use_imm_d      = 1'b1;
        force_rs1_zero = 1'b1;
        imm_d          = imm_u(i_instruction);
      end
      OPC_AUIPC: begin
        reg_write_d = 1'b1;
        use_imm_d   = 1'b1;
        imm_d       = imm_u(i_instruction);
      end
      OPC_JAL: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        imm_d       = imm_j(i_instruction);
      end
      OPC_JALR: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        use_imm_d   = 1'b1;
        imm_d       = imm_i(i_instruction);
      end
      OPC_BRANCH: begin
        branch_d = 1'b1;
        alu_d    = ALU_SUB;
        imm_d    = imm_b(i_instruction);
      end
      OPC_LOAD: begin
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
        use_imm_d   = 1'b1;
        imm_d       = imm_i(i_instruction);
      end
      OPC_STORE: begin
        mem_write_d = 1'b1;
        use_imm_d   = 1'b1;
        imm_d       = imm_s(i_instruction);
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Register file: x0 is never written, so reads of it are hard-wired to zero above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_wb_en && i_wb_addr != 5'd0) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // ---- stage p1: registered decode bundle ----
  logic                     vld_p1;
  logic [PC_WIDTH-1:0]      pc_p1;
  logic signed [DATA_W-1:0] rs1_p1, rs2_p1, imm_p1;
  logic [4:0]               rd_p1;
  logic [2:0]               funct3_p1;
  logic [3:0]               alu_p1;
  logic reg_write_p1, mem_read_p1, mem_write_p1, branch_p1, jump_p1, use_imm_p1, illegal_p1;

  always_ff @(posedge clk) begin
    if (rst || i_flush || (!i_stall && !i_valid)) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      imm_p1       <= '0;
      rd_p1        <= '0;
      funct3_p1    <= '0;
      alu_p1       <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      branch_p1    <= 1'b0;
      jump_p1      <= 1'b0;
      use_imm_p1   <= 1'b0;
      illegal_p1   <= 1'b0;
    end else if (!i_stall) begin
      vld_p1       <= 1'b1;
      pc_p1        <= i_process_counter;
      rs1_p1       <= force_rs1_zero ? '0 : rs1_val;
      rs2_p1       <= rs2_val;
      imm_p1       <= imm_d;
      rd_p1        <= reg_write_d ? rd : 5'd0;
      funct3_p1    <= funct3;
      alu_p1       <= alu_d;
      reg_write_p1 <= reg_write_d;
      mem_read_p1  <= mem_read_d;
      mem_write_p1 <= mem_write_d;
      branch_p1    <= branch_d;
      jump_p1      <= jump_d;
      use_imm_p1   <= use_imm_d;
      illegal_p1   <= illegal_d;
    end
  end

  assign o_valid           = vld_p1;
  assign o_process_counter = pc_p1;
  assign o_rs1_data        = rs1_p1;
  assign o_rs2_data        = rs2_p1;
  assign o_imm             = imm_p1;
  assign o_rd              = rd_p1;
  assign o_funct3          = funct3_p1;
  assign o_alu_op          = alu_p1;
  assign o_reg_write       = reg_write_p1;
  assign o_mem_read        = mem_read_p1;
  assign o_mem_write       = mem_write_p1;
  assign o_branch          = branch_p1;
  assign o_jump            = jump_p1;
  assign o_use_imm         = use_imm_p1;
  assign o_illegal         = illegal_p1;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with hand-computed expected bundles.
module tb_instruction_decode;

  localparam int PC_WIDTH = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         i_instruction;
  logic [PC_WIDTH-1:0] i_process_counter;
  logic                i_valid, i_stall, i_flush;
  logic                i_wb_en;
  logic [4:0]          i_wb_addr;
  logic [31:0]         i_wb_data;
  logic                o_valid;
  logic [PC_WIDTH-1:0] o_process_counter;
  logic [31:0]         o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]          o_rd;
  logic [2:0]          o_funct3;
  logic [3:0]          o_alu_op;
  logic o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_use_imm, o_illegal;

  int checks = 0;
  int failures = 0;

  instruction_decode #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .i_instruction(i_instruction), .i_process_counter(i_process_counter),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .o_process_counter(o_process_counter),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rd(o_rd), .o_funct3(o_funct3), .o_alu_op(o_alu_op),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_branch(o_branch), .o_jump(o_jump), .o_use_imm(o_use_imm), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control bits packed {reg_write, mem_read, mem_write, branch, jump, use_imm, illegal}.
  function automatic logic [6:0] ctrl();
    return {o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_use_imm, o_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [15:0] pc, input logic v);
    i_instruction     = ins;
    i_process_counter = pc;
    i_valid           = v;
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"}, o_valid, 1'b0);
    check_eq({tag, "_ctrl"}, ctrl(), 7'b0);
    check_eq({tag, "_imm"}, o_imm, 32'h0);
    check_eq({tag, "_rd"}, o_rd, 5'd0);
    check_eq({tag, "_pc"}, o_process_counter, 16'h0);
    check_eq({tag, "_rs"}, {o_rs1_data, o_rs2_data}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    drive(32'h00E00113, 16'h1234, 1'b1);
    repeat (10) step();
    check_bubble("reset");
    check_eq("reset_alu_f3", {o_alu_op, o_funct3}, 7'h0);
    rst = 1'b0;

    // addi x2,x0,14
    drive(32'h00E00113, 16'h0000, 1'b1);
    step();
    check_eq("addi_valid", o_valid, 1'b1);
    check_eq("addi_imm", o_imm, 32'd14);
    check_eq("addi_rd", o_rd, 5'd2);
    check_eq("addi_rs1", o_rs1_data, 32'h0);
    check_eq("addi_alu", o_alu_op, 4'd0);
    check_eq("addi_ctrl", ctrl(), 7'b1000010);
    check_eq("addi_pc", o_process_counter, 16'h0);

    // add x6,x5,x5 with same-cycle write-back of x5
    drive(32'h00528333, 16'h0004, 1'b1);
    i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
    step();
    i_wb_en = 1'b0;
    check_eq("byp_rs1", o_rs1_data, 32'hDEADBEEF);
    check_eq("byp_rs2", o_rs2_data, 32'hDEADBEEF);
    check_eq("add_rd", o_rd, 5'd6);
    check_eq("add_ctrl", ctrl(), 7'b1000000);
    check_eq("add_alu", o_alu_op, 4'd0);

    // sub x7,x5,x2: x5 from register file, x2 never written
    drive(32'h402283B3, 16'h0008, 1'b1);
    step();
    check_eq("sub_rs1", o_rs1_data, 32'hDEADBEEF);
    check_eq("sub_rs2", o_rs2_data, 32'h0);
    check_eq("sub_alu", o_alu_op, 4'd1);
    check_eq("sub_rd", o_rd, 5'd7);

    // Stall: capture addi at pc 0x10, then hold 3 cycles with changing input
    drive(32'h00E00113, 16'h0010, 1'b1);
    step();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h402283B3 + (k << 7), 16'h0020 + 16'(k * 4), 1'b1);
      i_wb_en = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h0000_0A00 + 32'(k);
      step();
      check_eq("stall_imm", o_imm, 32'd14);
      check_eq("stall_pc", o_process_counter, 16'h0010);
      check_eq("stall_rd_valid", {o_rd, o_valid, o_alu_op}, {5'd2, 1'b1, 4'd0});
    end
    i_wb_en = 1'b0;
    i_flush = 1'b1;
    step();
    check_bubble("flush_stall");
    i_flush = 1'b0; i_stall = 1'b0;

    // Write-back during the stall landed: addi x1,x9,0 reads x9 = 0xA02
    drive(32'h00048093, 16'h0030, 1'b1);
    step();
    check_eq("stall_wb", o_rs1_data, 32'h0000_0A02);

    // beq x0,x0,-8
    drive(32'hFE000CE3, 16'h0040, 1'b1);
    step();
    check_eq("beq_imm", o_imm, 32'hFFFFFFF8);
    check_eq("beq_ctrl", ctrl(), 7'b0001000);
    check_eq("beq_alu", o_alu_op, 4'd1);
    check_eq("beq_rd", o_rd, 5'd0);

    // Illegal opcode 1111111 with rd field 31
    drive(32'h00000FFF, 16'h0044, 1'b1);
    step();
    check_eq("ill_valid", o_valid, 1'b1);
    check_eq("ill_ctrl", ctrl(), 7'b0000001);
    check_eq("ill_rd", o_rd, 5'd0);

    // srai x3,x2,5
    drive(32'h40515193, 16'h0048, 1'b1);
    step();
    check_eq("srai_alu", o_alu_op, 4'd7);
    check_eq("srai_imm_f3", {o_imm, 1'b0, o_funct3}, {32'd1029, 1'b0, 3'd5});

    // lui x1,0x12345 with rs1 field = x8 being bypassed: operand must still be 0
    drive(32'h123450B7, 16'h004C, 1'b1);
    i_wb_en = 1'b1; i_wb_addr = 5'd8; i_wb_data = 32'h55;
    step();
    i_wb_en = 1'b0;
    check_eq("lui_imm", o_imm, 32'h12345000);
    check_eq("lui_rs1", o_rs1_data, 32'h0);
    check_eq("lui_ctrl", ctrl(), 7'b1000010);

    // sw x5,8(x0): S-immediate split fields
    drive(32'h00502423, 16'h0050, 1'b1);
    step();
    check_eq("sw_imm", o_imm, 32'd8);
    check_eq("sw_ctrl_rd", {ctrl(), o_rd}, {7'b0010010, 5'd0});
    check_eq("sw_rs2", o_rs2_data, 32'hDEADBEEF);

    // Capture with i_valid=0 loads a bubble
    drive(32'h00E00113, 16'h0054, 1'b0);
    step();
    check_bubble("invalid");

    // Reset during stall discards held bundle; write-back ignored and registers cleared
    drive(32'h00E00113, 16'h0058, 1'b1);
    step();
    i_stall = 1'b1; rst = 1'b1;
    i_wb_en = 1'b1; i_wb_addr = 5'd10; i_wb_data = 32'h77;
    step();
    check_bubble("rst_stall");
    rst = 1'b0; i_stall = 1'b0; i_wb_en = 1'b0;
    drive(32'h00528333, 16'h005C, 1'b1);
    step();
    check_eq("rst_cleared_x5", o_rs1_data, 32'h0);
    drive(32'h00050093, 16'h0060, 1'b1);
    step();
    check_eq("rst_no_wb_x10", o_rs1_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
